ide_data_fifo: RTL and testbench

- PIO data-register path for the emulated IDE device, sitting beside the IDE register-file block.
- The IDE front end supplies decoded, single-cycle strobes for completed host accesses to the Data register (CS1FX_, DA=0); this block buffers 16-bit words between the host and the soft CPU.
- The soft CPU accesses the buffer through the same 8-bit SRAM-style slave bus as the task-file registers, so byte pairs are assembled into and split out of words.
- Outputs feed the data-bus driver and the DRQ status logic.

---
 rtl/ide_data_fifo.sv | 164 ++++++++++++++++
 tb/tb_ide_data_fifo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ide_data_fifo.sv
// ide_data_fifo: PIO Data-register buffer for the emulated IDE device.
// Buffers 16-bit words between the IDE host side and the soft CPU's 8-bit
// SRAM-style slave bus. dir selects which side pushes and which side pops.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   ide_rd_strobe     host completed a Data register read (pop when dir=0)
//   ide_wr_strobe     host completed a Data register write (push when dir=1)
//   ide_wr_data       word written by the host
//   ide_rd_data       registered head word for the DD driver (0 when empty)
//   data_ready        registered: dir=0 -> !empty, dir=1 -> !full
//   sram_a/d_in/d_out CPU register select, write data, read data (comb)
//   sram_cs/we/oe     CPU chip select, write and read strobes
module ide_data_fifo #(
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ide_rd_strobe,
  input  logic        ide_wr_strobe,
  input  logic [15:0] ide_wr_data,
  output logic [15:0] ide_rd_data,
  output logic        data_ready,
  input  logic [1:0]  sram_a,
  input  logic [7:0]  sram_d_in,
  output logic [7:0]  sram_d_out,
  input  logic        sram_cs,
  input  logic        sram_we,
  input  logic        sram_oe
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  logic [15:0] mem_q [Depth];

  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  cnt_t        count_q, count_d;
  logic        dir_q, dir_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;
  logic [7:0]  lo_latch_q, lo_latch_d;
  logic [15:0] head_q, head_d;
  logic        data_ready_q, data_ready_d;

  logic        cpu_wr, cpu_rd, ctrl_wr, flush;
  logic        full, empty, full_d, empty_d;
  logic        push_req, pop_req, push_ok, pop_ok;
  logic [15:0] push_data;

  assign cpu_wr  = sram_cs & sram_we;
  assign cpu_rd  = sram_cs & sram_oe;
  assign ctrl_wr = cpu_wr && (sram_a == 2'd2);
  assign flush   = ctrl_wr && sram_d_in[0];

  assign full  = (count_q == cnt_t'(Depth));
  assign empty = (count_q == '0);

  // Side selection uses the current dir; a dir write only affects later cycles.
  assign push_req  = dir_q ? ide_wr_strobe : (cpu_wr && (sram_a == 2'd1));
  assign pop_req   = dir_q ? (cpu_rd && (sram_a == 2'd1)) : ide_rd_strobe;
  assign push_data = dir_q ? ide_wr_data : {sram_d_in, lo_latch_q};

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    push_ok    = 1'b0;
    pop_ok     = 1'b0;
    dir_d      = ctrl_wr ? sram_d_in[7] : dir_q;
    lo_latch_d = (cpu_wr && (sram_a == 2'd0)) ? sram_d_in : lo_latch_q;

    if (flush) begin
      // Flush wins over any same-cycle push/pop, which are dropped silently.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (ctrl_wr && sram_d_in[6]) ovf_d = 1'b0;
      if (ctrl_wr && sram_d_in[5]) udf_d = 1'b0;

      pop_ok = pop_req && !empty;
      if (pop_req && empty) udf_d = 1'b1;

      // A same-cycle pop frees a slot, so a push into a full FIFO still fits.
      push_ok = push_req && (!full || pop_ok);
      if (push_req && !push_ok) ovf_d = 1'b1;

      if (push_ok) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + ptr_t'(1);

      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end

    full_d  = (count_d == cnt_t'(Depth));
    empty_d = (count_d == '0);

    // The new head may be the slot being written this cycle; forward it.
    if (empty_d) begin
      head_d = 16'h0000;
    end else if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
      head_d = push_data;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end

    data_ready_d = dir_d ? !full_d : !empty_d;
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dir_q        <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      lo_latch_q   <= 8'h00;
      head_q       <= 16'h0000;
      data_ready_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dir_q        <= dir_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      lo_latch_q   <= lo_latch_d;
      head_q       <= head_d;
      data_ready_q <= data_ready_d;
    end
  end

  assign ide_rd_data = head_q;
  assign data_ready  = data_ready_q;

  always_comb begin
    sram_d_out = 8'h00;
    unique case (sram_a)
      2'd0: sram_d_out = head_q[7:0];
      2'd1: sram_d_out = head_q[15:8];
      2'd2: sram_d_out = {dir_q, ovf_q, udf_q, full, empty, 3'b000};
      2'd3: sram_d_out = 8'(count_q);
    endcase
  end

endmodule

// File: tb/tb_ide_data_fifo.sv
// Directed self-checking bench for ide_data_fifo (default depth 32).
module tb_ide_data_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        ide_rd_strobe, ide_wr_strobe;
  logic [15:0] ide_wr_data, ide_rd_data;
  logic        data_ready;
  logic [1:0]  sram_a;
  logic [7:0]  sram_d_in, sram_d_out;
  logic        sram_cs, sram_we, sram_oe;

  int n_checks = 0;
  int n_errors = 0;

  ide_data_fifo #(.DEPTH_LOG2(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .ide_rd_strobe(ide_rd_strobe),
    .ide_wr_strobe(ide_wr_strobe),
    .ide_wr_data  (ide_wr_data),
    .ide_rd_data  (ide_rd_data),
    .data_ready   (data_ready),
    .sram_a       (sram_a),
    .sram_d_in    (sram_d_in),
    .sram_d_out   (sram_d_out),
    .sram_cs      (sram_cs),
    .sram_we      (sram_we),
    .sram_oe      (sram_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks start and end at posedge+1.
  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    sram_a = a; sram_d_in = d; sram_cs = 1'b1; sram_we = 1'b1;
    @(posedge clk); #1;
    sram_cs = 1'b0; sram_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    sram_a = a; sram_cs = 1'b1; sram_oe = 1'b1;
    #1 d = sram_d_out;
    @(posedge clk); #1;
    sram_cs = 1'b0; sram_oe = 1'b0;
  endtask

  task automatic ide_wr(input logic [15:0] w);
    ide_wr_data = w; ide_wr_strobe = 1'b1;
    @(posedge clk); #1;
    ide_wr_strobe = 1'b0;
  endtask

  task automatic ide_rd();
    ide_rd_strobe = 1'b1;
    @(posedge clk); #1;
    ide_rd_strobe = 1'b0;
  endtask

  logic [7:0] b;

  initial begin
    rst = 1'b1;
    ide_rd_strobe = 1'b0; ide_wr_strobe = 1'b0; ide_wr_data = 16'h0;
    sram_a = 2'd0; sram_d_in = 8'h00; sram_cs = 1'b0; sram_we = 1'b0; sram_oe = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_head", ide_rd_data, 16'h0000);
    check("rst_ready", {15'h0, data_ready}, 16'h0);
    cpu_read(2'd2, b); check("rst_status", {8'h0, b}, 16'h0008);
    cpu_read(2'd3, b); check("rst_count", {8'h0, b}, 16'h0000);

    // Device -> host
    cpu_write(2'd0, 8'h34);
    cpu_write(2'd1, 8'h12);
    check("d2h_head1", ide_rd_data, 16'h1234);
    check("d2h_ready", {15'h0, data_ready}, 16'h1);
    cpu_write(2'd0, 8'h78);
    cpu_write(2'd1, 8'h56);
    cpu_read(2'd3, b); check("d2h_count2", {8'h0, b}, 16'h0002);
    cpu_read(2'd0, b); check("d2h_lo_peek", {8'h0, b}, 16'h0034);
    cpu_read(2'd1, b); check("d2h_hi_nopop", {8'h0, b}, 16'h0012);
    ide_rd();
    check("d2h_head2", ide_rd_data, 16'h5678);
    ide_rd();
    check("d2h_head_empty", ide_rd_data, 16'h0000);
    cpu_read(2'd2, b); check("d2h_status_empty", {8'h0, b}, 16'h0008);
    check("d2h_ready_empty", {15'h0, data_ready}, 16'h0);

    // Host -> device
    cpu_write(2'd2, 8'h80);
    check("h2d_ready", {15'h0, data_ready}, 16'h1);
    ide_wr(16'hBEEF);
    ide_wr(16'hCAFE);
    cpu_read(2'd0, b); check("h2d_b0", {8'h0, b}, 16'h00EF);
    cpu_read(2'd1, b); check("h2d_b1", {8'h0, b}, 16'h00BE);
    cpu_read(2'd0, b); check("h2d_b2", {8'h0, b}, 16'h00FE);
    cpu_read(2'd1, b); check("h2d_b3", {8'h0, b}, 16'h00CA);
    cpu_read(2'd2, b); check("h2d_status", {8'h0, b}, 16'h0088);

    // Full / overflow
    for (int i = 0; i < 32; i++) ide_wr(16'h1000 + 16'(i));
    cpu_read(2'd2, b); check("full_status", {8'h0, b}, 16'h0090);
    cpu_read(2'd3, b); check("full_count", {8'h0, b}, 16'h0020);
    check("full_ready", {15'h0, data_ready}, 16'h0);
    ide_wr(16'hDEAD);
    cpu_read(2'd2, b); check("ovf_status", {8'h0, b}, 16'h00D0);
    cpu_read(2'd3, b); check("ovf_count", {8'h0, b}, 16'h0020);
    cpu_write(2'd2, 8'hC0);
    cpu_read(2'd2, b); check("ovf_cleared", {8'h0, b}, 16'h0090);
    // Push and pop together while full
    ide_wr_data = 16'h2000; ide_wr_strobe = 1'b1;
    sram_a = 2'd1; sram_cs = 1'b1; sram_oe = 1'b1;
    #1 b = sram_d_out;
    @(posedge clk); #1;
    ide_wr_strobe = 1'b0; sram_cs = 1'b0; sram_oe = 1'b0;
    check("pp_popped_hi", {8'h0, b}, 16'h0010);
    cpu_read(2'd3, b); check("pp_count", {8'h0, b}, 16'h0020);
    cpu_read(2'd2, b); check("pp_status", {8'h0, b}, 16'h0090);
    for (int i = 0; i < 32; i++) begin
      check("drain_head", ide_rd_data, (i < 31) ? 16'h1001 + 16'(i) : 16'h2000);
      cpu_read(2'd1, b);
    end
    cpu_read(2'd2, b); check("drain_status", {8'h0, b}, 16'h0088);

    // Wrap-around, alternating push/pop
    for (int i = 0; i < 40; i++) begin
      ide_wr(16'h3000 + 16'(i));
      check("wrap_head", ide_rd_data, 16'h3000 + 16'(i));
      cpu_read(2'd1, b);
    end
    cpu_read(2'd1, b);
    cpu_read(2'd2, b); check("udf_status", {8'h0, b}, 16'h00A8);
    cpu_write(2'd2, 8'hA0);
    cpu_read(2'd2, b); check("udf_cleared", {8'h0, b}, 16'h0088);

    // Flush priority (dir=0, underflow set beforehand)
    cpu_write(2'd2, 8'h00);
    ide_rd();
    for (int i = 0; i < 5; i++) begin
      cpu_write(2'd0, 8'h40 + 8'(i));
      cpu_write(2'd1, 8'h90);
    end
    cpu_read(2'd2, b); check("pre_flush_status", {8'h0, b}, 16'h0020);
    cpu_read(2'd3, b); check("pre_flush_count", {8'h0, b}, 16'h0005);
    check("pre_flush_head", ide_rd_data, 16'h9040);
    sram_a = 2'd2; sram_d_in = 8'h01; sram_cs = 1'b1; sram_we = 1'b1;
    ide_rd_strobe = 1'b1;
    @(posedge clk); #1;
    sram_cs = 1'b0; sram_we = 1'b0; ide_rd_strobe = 1'b0;
    check("flush_head", ide_rd_data, 16'h0000);
    cpu_read(2'd2, b); check("flush_status", {8'h0, b}, 16'h0008);
    cpu_read(2'd3, b); check("flush_count", {8'h0, b}, 16'h0000);

    // Asynchronous reset mid-clock
    cpu_write(2'd0, 8'hAA);
    cpu_write(2'd1, 8'h55);
    check("pre_rst_head", ide_rd_data, 16'h55AA);
    #2 rst = 1'b1;
    #1 check("async_rst_head", ide_rd_data, 16'h0000);
    check("async_rst_ready", {15'h0, data_ready}, 16'h0);
    sram_a = 2'd2; #1 check("async_rst_status", {8'h0, sram_d_out}, 16'h0008);
    sram_a = 2'd3; #1 check("async_rst_count", {8'h0, sram_d_out}, 16'h0000);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_head", ide_rd_data, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
